// File: rtl/float_pipelined_lzc_normalizer_pkg.sv
// Shared constants and helpers for the pipelined LZC normalizer.
// Latency: n/a (package only).
// Backpressure: n/a. Group geometry helpers keep the group split identical everywhere it is used.
package float_pipelined_lzc_normalizer_pkg;

  // Register stages between input and output (S1..S3).
  localparam int NUM_STAGES = 3;

  // Number of groups the mantissa is split into, MSB group first.
  function automatic int num_groups(input int width, input int grp);
    return (width + grp - 1) / grp;
  endfunction

  // Width of the least-significant group; may be narrower than the others.
  function automatic int last_group_size(input int width, input int grp);
    return width - (num_groups(width, grp) - 1) * grp;
  endfunction

endpackage

// File: rtl/float_lzc_group.sv
// Combinational leading-zero count of one mantissa group plus a nonzero flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; follows whatever stage samples it.
// Ports: grp_dat (group bits, MSB first), lz (0..WIDTH), nonzero (any bit set).
module float_lzc_group #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] grp_dat,
  output logic [CW-1:0]    lz,
  output logic             nonzero
);

  // Scan upward so the highest set bit is the last one to write lz.
  always_comb begin
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (grp_dat[i]) lz = CW'(WIDTH - 1 - i);
    end
  end

  assign nonzero = |grp_dat;

endmodule

// File: rtl/float_pipelined_lzc_normalizer.sv
// Pipelined leading-zero counter + normalizing shifter: scaled count, MSB-aligned mantissa, zero flag, tag.
// Latency: 3 cycles (S1 group counts, S2 group select, S3 shift/scale) with no backpressure.
// Backpressure: valid/ready; each stage advances when empty or when the next advances, bubbles collapse.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_data/in_tag;
//        out_valid/out_ready/out_count/out_mant/out_zero/out_tag.
module float_pipelined_lzc_normalizer
  import float_pipelined_lzc_normalizer_pkg::*;
#(
  parameter int INPUT_WIDTH  = 24,
  parameter int OUTPUT_WIDTH = 5,
  parameter int OUTPUT_STEP  = 1,
  parameter int OUTPUT_BIAS  = 0,
  parameter int GROUP_SIZE   = 8,
  parameter int TAG_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_data,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_count,
  output logic [INPUT_WIDTH-1:0]  out_mant,
  output logic                    out_zero,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int NG      = num_groups(INPUT_WIDTH, GROUP_SIZE);
  localparam int LAST_GS = last_group_size(INPUT_WIDTH, GROUP_SIZE);
  localparam int LCW     = $clog2(GROUP_SIZE + 1);
  localparam int LZW     = $clog2(INPUT_WIDTH + 1);

  // ---------------- stage valid / advance ----------------
  logic [NUM_STAGES-1:0] stg_vld_q, stg_vld_d, stg_adv, stg_in_vld;

  assign stg_in_vld = {stg_vld_q[NUM_STAGES-2:0], in_valid};

  // A stage advances unless it and every stage after it are full and the
  // output is stalled; written flat so no combinational chain forms.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    assign stg_adv[k]   = out_ready | ~(&stg_vld_q[NUM_STAGES-1:k]);
    assign stg_vld_d[k] = stg_adv[k] ? stg_in_vld[k] : stg_vld_q[k];
  end

  assign in_ready  = stg_adv[0] & ~reset;
  assign out_valid = stg_vld_q[NUM_STAGES-1];

  // ---------------- S1: per-group counts ----------------
  logic [LCW-1:0] grp_lz [NG];
  logic [NG-1:0]  grp_nz;

  // Group 0 is the most significant; the last group takes the leftover bits.
  for (genvar g = 0; g < NG; g++) begin : g_grp
    if (g == NG - 1) begin : g_last
      float_lzc_group #(.WIDTH(LAST_GS), .CW(LCW)) u_grp (
        .grp_dat (in_data[LAST_GS-1:0]),
        .lz      (grp_lz[g]),
        .nonzero (grp_nz[g])
      );
    end else begin : g_full
      float_lzc_group #(.WIDTH(GROUP_SIZE), .CW(LCW)) u_grp (
        .grp_dat (in_data[INPUT_WIDTH-1-g*GROUP_SIZE -: GROUP_SIZE]),
        .lz      (grp_lz[g]),
        .nonzero (grp_nz[g])
      );
    end
  end

  logic [INPUT_WIDTH-1:0] s1_dat_q, s1_dat_d;
  logic [TAG_WIDTH-1:0]   s1_tag_q, s1_tag_d;
  logic [LCW-1:0]         s1_lz_q [NG];
  logic [LCW-1:0]         s1_lz_d [NG];
  logic [NG-1:0]          s1_nz_q, s1_nz_d;

  always_comb begin
    s1_dat_d = s1_dat_q;
    s1_tag_d = s1_tag_q;
    s1_lz_d  = s1_lz_q;
    s1_nz_d  = s1_nz_q;
    if (stg_adv[0]) begin
      s1_dat_d = in_data;
      s1_tag_d = in_tag;
      s1_lz_d  = grp_lz;
      s1_nz_d  = grp_nz;
    end
  end

  // ---------------- S2: pick most-significant nonzero group ----------------
  logic [LZW-1:0]         s2_lz_c;
  logic                   s2_zero_c;
  logic [INPUT_WIDTH-1:0] s2_dat_q, s2_dat_d;
  logic [TAG_WIDTH-1:0]   s2_tag_q, s2_tag_d;
  logic [LZW-1:0]         s2_lz_q, s2_lz_d;
  logic                   s2_zero_q, s2_zero_d;

  // Walk from the LSB group upward so the highest nonzero group wins.
  always_comb begin
    s2_lz_c   = LZW'(INPUT_WIDTH);
    s2_zero_c = 1'b1;
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_nz_q[g]) begin
        s2_lz_c   = LZW'(g * GROUP_SIZE) + LZW'(s1_lz_q[g]);
        s2_zero_c = 1'b0;
      end
    end
  end

  always_comb begin
    s2_dat_d  = s2_dat_q;
    s2_tag_d  = s2_tag_q;
    s2_lz_d   = s2_lz_q;
    s2_zero_d = s2_zero_q;
    if (stg_adv[1]) begin
      s2_dat_d  = s1_dat_q;
      s2_tag_d  = s1_tag_q;
      s2_lz_d   = s2_lz_c;
      s2_zero_d = s2_zero_c;
    end
  end

  // ---------------- S3: normalize and scale ----------------
  logic [INPUT_WIDTH-1:0]  s3_mant_q, s3_mant_d;
  logic [OUTPUT_WIDTH-1:0] s3_count_q, s3_count_d;
  logic                    s3_zero_q, s3_zero_d;
  logic [TAG_WIDTH-1:0]    s3_tag_q, s3_tag_d;

  // A zero input has lz == INPUT_WIDTH, so the shift already yields zero.
  always_comb begin
    s3_mant_d  = s3_mant_q;
    s3_count_d = s3_count_q;
    s3_zero_d  = s3_zero_q;
    s3_tag_d   = s3_tag_q;
    if (stg_adv[2]) begin
      s3_mant_d  = s2_dat_q << s2_lz_q;
      s3_count_d = OUTPUT_WIDTH'(OUTPUT_BIAS + OUTPUT_STEP * int'(s2_lz_q));
      s3_zero_d  = s2_zero_q;
      s3_tag_d   = s2_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_vld_q  <= '0;
      s1_dat_q   <= '0;
      s1_tag_q   <= '0;
      s1_nz_q    <= '0;
      for (int g = 0; g < NG; g++) s1_lz_q[g] <= '0;
      s2_dat_q   <= '0;
      s2_tag_q   <= '0;
      s2_lz_q    <= '0;
      s2_zero_q  <= 1'b0;
      s3_mant_q  <= '0;
      s3_count_q <= '0;
      s3_zero_q  <= 1'b0;
      s3_tag_q   <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      s1_dat_q   <= s1_dat_d;
      s1_tag_q   <= s1_tag_d;
      s1_nz_q    <= s1_nz_d;
      s1_lz_q    <= s1_lz_d;
      s2_dat_q   <= s2_dat_d;
      s2_tag_q   <= s2_tag_d;
      s2_lz_q    <= s2_lz_d;
      s2_zero_q  <= s2_zero_d;
      s3_mant_q  <= s3_mant_d;
      s3_count_q <= s3_count_d;
      s3_zero_q  <= s3_zero_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

  assign out_count = s3_count_q;
  assign out_mant  = s3_mant_q;
  assign out_zero  = s3_zero_q;
  assign out_tag   = s3_tag_q;

endmodule

// File: tb/tb_float_pipelined_lzc_normalizer.sv
// Scoreboard bench for the pipelined LZC normalizer: default instance plus two re-parameterized ones.
// Latency: checked at 3 cycles for beats sent with the output ready.
// Backpressure: out_ready held low / toggled; in_ready compared against a bench occupancy count.
module tb_float_pipelined_lzc_normalizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- default instance ----------------
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [23:0] in_data, out_mant;
  logic [7:0]  in_tag, out_tag;
  logic [4:0]  out_count;

  float_pipelined_lzc_normalizer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_mant(out_mant), .out_zero(out_zero), .out_tag(out_tag)
  );

  // ---------------- STEP=2, BIAS=3, 6-bit count ----------------
  logic        x_in_valid, x_out_ready;
  logic        x1_in_ready, x1_out_valid, x1_out_zero;
  logic [23:0] x1_in_data, x1_out_mant;
  logic [7:0]  x_in_tag, x1_out_tag;
  logic [5:0]  x1_out_count;

  float_pipelined_lzc_normalizer #(.OUTPUT_WIDTH(6), .OUTPUT_STEP(2), .OUTPUT_BIAS(3)) dut_scaled (
    .clk(clk), .reset(reset),
    .in_valid(x_in_valid), .in_ready(x1_in_ready), .in_data(x1_in_data), .in_tag(x_in_tag),
    .out_valid(x1_out_valid), .out_ready(x_out_ready), .out_count(x1_out_count),
    .out_mant(x1_out_mant), .out_zero(x1_out_zero), .out_tag(x1_out_tag)
  );

  // ---------------- 20-bit input, 4-bit low group ----------------
  logic        x2_in_ready, x2_out_valid, x2_out_zero;
  logic [19:0] x2_in_data, x2_out_mant;
  logic [7:0]  x2_out_tag;
  logic [4:0]  x2_out_count;

  float_pipelined_lzc_normalizer #(.INPUT_WIDTH(20)) dut_narrow (
    .clk(clk), .reset(reset),
    .in_valid(x_in_valid), .in_ready(x2_in_ready), .in_data(x2_in_data), .in_tag(x_in_tag),
    .out_valid(x2_out_valid), .out_ready(x_out_ready), .out_count(x2_out_count),
    .out_mant(x2_out_mant), .out_zero(x2_out_zero), .out_tag(x2_out_tag)
  );

  // ---------------- scoreboards ----------------
  typedef struct {
    logic [4:0]  count;
    logic [23:0] mant;
    logic        zero;
    logic [7:0]  tag;
    int          acc;
    bit          chk_lat;
  } exp_t;

  typedef struct {
    logic [31:0] count;
    logic [31:0] mant;
    logic        zero;
  } xexp_t;

  exp_t  sb[$];
  xexp_t q1[$];
  xexp_t q2[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- out_ready driver ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // ---------------- monitor: default instance ----------------
  int          occ = 0;
  bit          prev_stall = 0;
  logic [38:0] held;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      occ        = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_hold", {out_count, out_mant, out_zero, out_tag}, held);
      end
      chk("in_ready_occ", in_ready, (occ < 3) || out_ready);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got mant %0h with no beat expected", out_mant);
        end else begin
          e = sb.pop_front();
          chk("count", out_count, e.count);
          chk("mant", out_mant, e.mant);
          chk("zero", out_zero, e.zero);
          chk("tag", out_tag, e.tag);
          if (e.chk_lat) chk("latency", cyc - e.acc, 3);
        end
      end
      occ        = occ + int'(in_valid && in_ready) - int'(out_valid && out_ready);
      prev_stall = out_valid && !out_ready;
      held       = {out_count, out_mant, out_zero, out_tag};
    end
  end

  // ---------------- monitors: re-parameterized instances ----------------
  always @(negedge clk) begin
    xexp_t e;
    if (!reset && x1_out_valid) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL x1_unexpected: got count %0d with no beat expected", x1_out_count);
      end else begin
        e = q1.pop_front();
        chk("x1_count", x1_out_count, e.count);
        chk("x1_mant", x1_out_mant, e.mant);
        chk("x1_zero", x1_out_zero, e.zero);
      end
    end
    if (!reset && x2_out_valid) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL x2_unexpected: got count %0d with no beat expected", x2_out_count);
      end else begin
        e = q2.pop_front();
        chk("x2_count", x2_out_count, e.count);
        chk("x2_mant", x2_out_mant, e.mant);
        chk("x2_zero", x2_out_zero, e.zero);
      end
    end
  end

  // ---------------- stimulus tasks (entered at posedge + #1) ----------------
  task automatic send(input logic [23:0] d, input logic [7:0] t, input logic [4:0] c,
                      input logic [23:0] m, input logic z, input bit lat);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for data %0h", d);
    end else begin
      e.count = c; e.mant = m; e.zero = z; e.tag = t; e.acc = cyc; e.chk_lat = lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_x(input logic [23:0] d1, input logic [5:0] c1, input logic [23:0] m1, input logic z1,
                        input logic [19:0] d2, input logic [4:0] c2, input logic [19:0] m2, input logic z2);
    xexp_t e;
    x_in_valid = 1'b1;
    x1_in_data = d1;
    x2_in_data = d2;
    @(negedge clk);
    chk("x1_in_ready", x1_in_ready, 1'b1);
    chk("x2_in_ready", x2_in_ready, 1'b1);
    e.count = 32'(c1); e.mant = 32'(m1); e.zero = z1; q1.push_back(e);
    e.count = 32'(c2); e.mant = 32'(m2); e.zero = z2; q2.push_back(e);
    @(posedge clk);
    #1;
    x_in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d beats never emerged", name, sb.size() + q1.size() + q2.size());
      sb.delete(); q1.delete(); q2.delete();
    end
  endtask

  // Stream vectors with hand-computed leading zeros and normalized mantissas.
  logic [23:0] st_dat  [10] = '{24'h400000, 24'h00FFFF, 24'h000001, 24'h123456, 24'h0000F0,
                                24'h00A000, 24'hFFFFFF, 24'h000300, 24'h0F0000, 24'h000000};
  logic [4:0]  st_cnt  [10] = '{5'd1, 5'd8, 5'd23, 5'd3, 5'd16, 5'd8, 5'd0, 5'd14, 5'd4, 5'd24};
  logic [23:0] st_mant [10] = '{24'h800000, 24'hFFFF00, 24'h800000, 24'h91A2B0, 24'hF00000,
                                24'hA00000, 24'hFFFFFF, 24'hC00000, 24'hF00000, 24'h000000};

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_tag     = '0;
    x_in_valid = 1'b0;
    x_out_ready = 1'b1;
    x_in_tag   = '0;
    x1_in_data = '0;
    x2_in_data = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_count", out_count, 5'd0);
    chk("rst_out_mant", out_mant, 24'd0);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_out_tag", out_tag, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed beats, back to back, latency checked.
    send(24'h800000, 8'h01, 5'd0,  24'h800000, 1'b0, 1'b1);
    send(24'h000800, 8'h5A, 5'd12, 24'h800000, 1'b0, 1'b1);
    send(24'h000000, 8'h03, 5'd24, 24'h000000, 1'b1, 1'b1);
    drain("directed_drain");

    // Fill the pipe with the output stalled: in_ready must drop after three.
    @(posedge clk);
    #1;
    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(st_dat[i], 8'(8'h10 + i), st_cnt[i], st_mant[i], st_dat[i] == 0, 1'b0);
    @(negedge clk);
    chk("in_ready_full", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rdy_mode = 1;
    for (int i = 3; i < 10; i++) send(st_dat[i], 8'(8'h10 + i), st_cnt[i], st_mant[i], st_dat[i] == 0, 1'b0);
    drain("stream_drain");
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with two beats in flight; they must vanish.
    send(24'h00000F, 8'hE1, 5'd20, 24'hF00000, 1'b0, 1'b0);
    send(24'h000002, 8'hE2, 5'd22, 24'h800000, 1'b0, 1'b0);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    send(24'h000040, 8'h77, 5'd17, 24'h800000, 1'b0, 1'b1);
    drain("post_reset_drain");
    repeat (4) @(posedge clk);
    #1;

    // Re-parameterized instances.
    send_x(24'h000001, 6'd49, 24'h800000, 1'b0, 20'h00008, 5'd16, 20'h80000, 1'b0);
    send_x(24'h000000, 6'd51, 24'h000000, 1'b1, 20'h00000, 5'd20, 20'h00000, 1'b1);
    send_x(24'h800000, 6'd3,  24'h800000, 1'b0, 20'h80000, 5'd0,  20'h80000, 1'b0);
    send_x(24'h00F000, 6'd19, 24'hF00000, 1'b0, 20'h00100, 5'd11, 20'h80000, 1'b0);
    drain("param_drain");
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
